// File: rtl/dataflow_pkg.sv
// Shared dataflow constants and helpers: the default word width and the
// pointer-width function used by buffer stages.
package dataflow_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pull_fifo_mem.sv
// Simple dual-port storage for pull_responder_fifo: one synchronous write
// port and one asynchronous read port. Contents are never reset.
module pull_fifo_mem
    import dataflow_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned depth      = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_width(depth)-1:0]  waddr,
    input  logic [data_width-1:0]        wdata,
    input  logic [ptr_width(depth)-1:0]  raddr,
    output logic [data_width-1:0]        rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pull_responder_fifo.sv
// Responder end of the dataflow req/ack pull protocol, backed by a circular
// buffer. Defining PULL_RESPONDER_COUNT_EN adds a 32-bit `served` counter port.
module pull_responder_fifo
    import dataflow_pkg::*;
#(
    parameter int unsigned data_width  = DATA_WIDTH,
    parameter int unsigned depth       = 8,
    parameter int unsigned output_size = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [data_width-1:0]             wr_data,
    output logic                              full,
    output logic                              empty,
    output logic [ptr_width(depth):0]         level,
    input  logic [output_size-1:0]            req,
    output logic                              ack,
    output logic [data_width-1:0]             dout
`ifdef PULL_RESPONDER_COUNT_EN
    ,
    output logic [31:0]                       served
`endif
);

    localparam int unsigned PW = ptr_width(depth);
    localparam int unsigned LW = PW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [data_width-1:0] rd_word;
    logic                  wr_accept;
    logic                  serve;

    assign full  = (level == LW'(depth));
    assign empty = (level == '0);

    // ~ack keeps a still-high req in the ack cycle from triggering a second serve.
    assign wr_accept = wr_en & ~full;
    assign serve     = ~empty & (&req) & ~ack;

    pull_fifo_mem #(
        .data_width(data_width),
        .depth     (depth)
    ) u_mem (
        .clk  (clk),
        .we   (wr_accept),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ack    <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
            if (serve) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout   <= rd_word;
            end
            ack <= serve;
            case ({wr_accept, serve})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef PULL_RESPONDER_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       served <= '0;
        else if (serve) served <= served + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pull_responder_fifo.sv
// Directed, table-driven bench for pull_responder_fifo (depth 4, two-way join),
// with hand-written reset sequences at start and mid-transfer.
module tb_pull_responder_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OSIZE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [2:0]    level;
    logic [1:0]    req;
    logic          ack;
    logic [DW-1:0] dout;
`ifdef PULL_RESPONDER_COUNT_EN
    logic [31:0]   served;
`endif

    always #5 clk = ~clk;

    pull_responder_fifo #(
        .data_width (DW),
        .depth      (DEPTH),
        .output_size(OSIZE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .level  (level),
        .req    (req),
        .ack    (ack),
        .dout   (dout)
`ifdef PULL_RESPONDER_COUNT_EN
        ,
        .served (served)
`endif
    );

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic [1:0]    rq;
        logic          e_ack;
        logic [DW-1:0] e_dout;
        int unsigned   e_level;
    } vec_t;

    vec_t        vecs[$];
    int unsigned checks     = 0;
    int unsigned errors     = 0;
    int unsigned exp_served = 0;

    function automatic void add(input logic w, input logic [DW-1:0] d, input logic [1:0] r,
                                input logic ea, input logic [DW-1:0] ed, input int unsigned el);
        vec_t v;
        v.wr = w; v.data = d; v.rq = r; v.e_ack = ea; v.e_dout = ed; v.e_level = el;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic ea, input logic [DW-1:0] ed,
                               input int unsigned el);
        check({tag, " ack"},   {31'd0, ack}, {31'd0, ea});
        check({tag, " dout"},  dout, ed);
        check({tag, " level"}, {29'd0, level}, el);
        check({tag, " full"},  {31'd0, full}, {31'd0, (el == DEPTH)});
        check({tag, " empty"}, {31'd0, empty}, {31'd0, (el == 0)});
    endtask

    task automatic apply(input string tag, input vec_t v);
        wr_en = v.wr; wr_data = v.data; req = v.rq;
        @(posedge clk); #1;
        if (v.e_ack) exp_served++;
        check_state(tag, v.e_ack, v.e_dout, v.e_level);
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; req = '0;

        // basic serve: three words, requester holds req
        add(1, 32'h11, 2'b00, 0, 32'h0,  1);
        add(1, 32'h22, 2'b00, 0, 32'h0,  2);
        add(1, 32'h33, 2'b00, 0, 32'h0,  3);
        add(0, 32'h0,  2'b11, 1, 32'h11, 2);
        add(0, 32'h0,  2'b11, 0, 32'h11, 2);
        add(0, 32'h0,  2'b11, 1, 32'h22, 1);
        add(0, 32'h0,  2'b11, 0, 32'h22, 1);
        add(0, 32'h0,  2'b11, 1, 32'h33, 0);
        add(0, 32'h0,  2'b11, 0, 32'h33, 0);
        // empty stall, then write 0x5 while requesting
        for (int i = 0; i < 10; i++) add(0, 32'h0, 2'b11, 0, 32'h33, 0);
        add(1, 32'h5,  2'b11, 0, 32'h33, 1);
        add(0, 32'h0,  2'b11, 1, 32'h5,  0);
        add(0, 32'h0,  2'b00, 0, 32'h5,  0);
        // fill to depth, drop the fifth word, drain with pointer wrap
        for (int i = 0; i < 5; i++) add(1, 32'(i), 2'b00, 0, 32'h5, (i < 4) ? i + 1 : 4);
        add(0, 32'h0,  2'b11, 1, 32'h0,  3);
        add(0, 32'h0,  2'b00, 0, 32'h0,  3);
        add(0, 32'h0,  2'b11, 1, 32'h1,  2);
        add(0, 32'h0,  2'b00, 0, 32'h1,  2);
        add(1, 32'h7,  2'b00, 0, 32'h1,  3);
        add(1, 32'h8,  2'b00, 0, 32'h1,  4);
        add(0, 32'h0,  2'b11, 1, 32'h2,  3);
        add(0, 32'h0,  2'b00, 0, 32'h2,  3);
        add(0, 32'h0,  2'b11, 1, 32'h3,  2);
        add(0, 32'h0,  2'b00, 0, 32'h3,  2);
        add(0, 32'h0,  2'b11, 1, 32'h7,  1);
        add(0, 32'h0,  2'b00, 0, 32'h7,  1);
        add(0, 32'h0,  2'b11, 1, 32'h8,  0);
        add(0, 32'h0,  2'b00, 0, 32'h8,  0);
        // simultaneous write and serve at level 2
        add(1, 32'hA1, 2'b00, 0, 32'h8,  1);
        add(1, 32'hA2, 2'b00, 0, 32'h8,  2);
        add(1, 32'hA3, 2'b11, 1, 32'hA1, 2);
        add(0, 32'h0,  2'b00, 0, 32'hA1, 2);
        add(0, 32'h0,  2'b11, 1, 32'hA2, 1);
        add(0, 32'h0,  2'b00, 0, 32'hA2, 1);
        add(0, 32'h0,  2'b11, 1, 32'hA3, 0);
        add(0, 32'h0,  2'b00, 0, 32'hA3, 0);
        // partial join waits; full join serves once per ack gap
        add(1, 32'hB1, 2'b00, 0, 32'hA3, 1);
        add(1, 32'hB2, 2'b00, 0, 32'hA3, 2);
        for (int i = 0; i < 5; i++) add(0, 32'h0, 2'b01, 0, 32'hA3, 2);
        add(0, 32'h0,  2'b11, 1, 32'hB1, 1);
        add(0, 32'h0,  2'b11, 0, 32'hB1, 1);
        add(0, 32'h0,  2'b11, 1, 32'hB2, 0);
        add(0, 32'h0,  2'b00, 0, 32'hB2, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b0, 32'h0, 0);
`ifdef PULL_RESPONDER_COUNT_EN
        check("reset served", served, 32'd0);
`endif
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // reset asserted during an ack cycle
        v = '{wr: 1'b1, data: 32'hC1, rq: 2'b00, e_ack: 1'b0, e_dout: 32'hB2, e_level: 1};
        apply("mid_w1", v);
        v = '{wr: 1'b1, data: 32'hC2, rq: 2'b00, e_ack: 1'b0, e_dout: 32'hB2, e_level: 2};
        apply("mid_w2", v);
        v = '{wr: 1'b0, data: 32'h0,  rq: 2'b11, e_ack: 1'b1, e_dout: 32'hC1, e_level: 1};
        apply("mid_ack", v);
`ifdef PULL_RESPONDER_COUNT_EN
        check("served count", served, exp_served);
`endif
        wr_en = 1'b0; req = '0;
        rst = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 32'h0, 0);
`ifdef PULL_RESPONDER_COUNT_EN
        check("async_rst served", served, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        // pointers restart from zero after reset
        v = '{wr: 1'b1, data: 32'hD1, rq: 2'b00, e_ack: 1'b0, e_dout: 32'h0,  e_level: 1};
        apply("post_w", v);
        v = '{wr: 1'b0, data: 32'h0,  rq: 2'b11, e_ack: 1'b1, e_dout: 32'hD1, e_level: 0};
        apply("post_ack", v);
`ifdef PULL_RESPONDER_COUNT_EN
        check("post served", served, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pull_responder_fifo.md
# pull_responder_fifo

Synthesizable responder end of the dataflow req/ack pull protocol. It buffers words written by a host-side loader and serves them to one or more requesting async operators, returning an ack pulse with registered data. It replaces the behavioural producer model at graph inputs and decouples loading from consumption with a circular buffer of `depth` words.

## Interface
Parameters:
- `data_width`, 32: word width.
- `depth`, 8: buffer entries; power of two, at least 2.
- `output_size`, 1: number of requesters joined on the pull side.

Ports:
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: write strobe.
- `wr_data`, input, `data_width`: write word.
- `full`, output, 1: buffer holds `depth` words.
- `empty`, output, 1: buffer holds 0 words.
- `level`, output, `$clog2(depth)+1`: current occupancy, 0..`depth`.
- `req`, input, `output_size`: per-requester request; the join is the AND of all bits.
- `ack`, output, 1: registered ack pulse, shared by all requesters.
- `dout`, output, `data_width`: registered served word.

## Operation
- Storage is a circular buffer with read and write pointers. Each pointer is `$clog2(depth)` bits and wraps naturally from `depth-1` to 0.
- **Write:** accepted at an edge iff `wr_en & ~full`. The word is stored at `wr_ptr`, and `wr_ptr` increments.
- **Write when full:** `wr_en` while `full` drops the word silently. `full` is evaluated before any same-cycle pop, so there is no write-through at full.
- **Serve:** at an edge where `~empty & (&req) & ~ack`:
  - `ack` is set to 1.
  - `dout` takes `mem[rd_ptr]`.
  - `rd_ptr` increments.
- **Otherwise:** `ack` is set to 0, so `ack` is never high for two consecutive cycles.
- **`~ack` guard:** requesters drop `req` one cycle after seeing `ack`, so `req` is still high during the ack cycle. The guard prevents a double serve in that cycle.
- **Holding:** `dout` holds its value between acks.
- **Simultaneous write and serve:** when both occur in the same cycle, `level` is unchanged and both pointers advance.
- **Partial request:** with `output_size>1`, nothing is served until every `req` bit is high. Requesters that raised early keep waiting.
- **Occupancy:** `level` is write-accepted minus served, with no overflow or underflow. `full = (level==depth)`, `empty = (level==0)`.

## Timing
- **Reset values** (asynchronous on `rst` low, and also mid-transfer):
  - `ack`=0, `dout`=0, `level`=0, `empty`=1, `full`=0.
  - Both pointers are 0.
  - Buffer contents are not cleared.
  - An in-flight ack is aborted.
- **Write-to-serve latency:** a word written at edge E is first eligible for `ack` at edge E+1. Its `ack` and `dout` are visible in the cycle after E+1.
- **Request-to-ack latency:** with `req` high at edge E and data present, `ack` and `dout` are valid in the cycle after E.
- **Throughput:** one word per 3 cycles against a standard async operator requester (req, ack, req low, then req again). The block itself allows one word every 2 cycles.
- **Flag update:** `full`, `empty` and `level` are registered or derived from registered state. They update in the cycle after the causing edge.

## Configuration
- **`PULL_RESPONDER_COUNT_EN` defined:**
  - Adds output port `served` (32 bits).
  - Resets to 0 and increments on each serve.
  - Wraps at 2^32.
- **Not defined:** no `served` port and no counter logic. All other behaviour is identical.

## Structure
- **Shared package `dataflow_pkg`:**
  - Default `data_width` constant (32).
  - Function `ptr_width(depth)`.
- **Sub-module `pull_fifo_mem`:**
  - Simple dual-port storage with one write port and one asynchronous read port.
  - Pointers, flags and handshake stay in the top module.

## Test plan
- **Basic serve:** reset, write 0x11, 0x22, 0x33, then hold `req`=1 as an async operator requester does. Require acks returning 0x11, 0x22, 0x33 in order, no two consecutive `ack` cycles, and `level` stepping 3→0.
- **Empty stall:** `req` high with the buffer empty for 10 cycles gives `ack`=0 throughout. Write 0x5 at edge E; `ack` is 1 with `dout`=0x5 in the cycle after E+1.
- **Full, wrap and drop:** `depth`=4.
  - Write 0..4: word 4 is dropped and `full`=1.
  - Drain 2 words (0, 1), then write 7 and 8.
  - Drain: 2, 3, 7, 8, exercising pointer wrap.
- **Simultaneous write and serve** at `level`=2: `level` stays 2, and the served word is the oldest one.
- **Join:** `output_size`=2 with req=2'b01 for 5 cycles gives no ack. With req=2'b11, a single ack appears the next cycle.
- **Reset mid-transfer:**
  - Assert `rst` low during an `ack` cycle: `ack`=0, `dout`=0 and `level`=0 immediately, without a clock edge.
  - With `PULL_RESPONDER_COUNT_EN`, `served` returns to 0.
  - `served` equals the number of acks otherwise.
